if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised successor of the single-entry IF stage.
- Tracks up to DEPTH in-order instruction fetches already address-handshaken by pre-IF, buffers returned instructions, and delivers them in order to ID.
- Supports a same-cycle bypass from SRAM data to ID.
- Absorbs ws_ex/ws_eret flushes by counting in-flight responses to be discarded, so no stale instruction ever reaches ID.

Parameters:
- DEPTH, 4, queue entries and max outstanding SRAM responses; power of 2, >=2.
- PC_W, 32, PC / badvaddr width.
- INST_W, 32, instruction width.
- CNT_W, $clog2(DEPTH)+1, width of occupancy and outstanding counters.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  pre-IF pushes a fetch this cycle (SRAM addr handshake done, or req_ex).
- req_pc  in  PC_W  PC of pushed fetch.
- req_ex  in  1  fetch has address error (pc[1:0]!=0); no SRAM request was issued.
- req_ready  out  1  queue accepts a push this cycle.
- inst_sram_data_ok  in  1  one SRAM response this cycle.
- inst_sram_rdata  in  INST_W  response data.
- flush  in  1  ws_ex | ws_eret.
- ds_allowin  in  1  ID accepts.
- fs_to_ds_valid  out  1  head entry is deliverable.
- fs_to_ds_bus  out  1+PC_W+INST_W+PC_W  {ex, badvaddr, inst, pc}.
- inst_sram_data_waiting  out  1  any SRAM response still outstanding (queued or to-drop).
- fs_empty  out  1  no valid entries.

Behaviour:
- State:
  - Per entry: pc, ex, inst, done.
  - rptr, wptr, fptr (fill pointer), count (CNT_W), pend (non-ex entries not done), drop_cnt (CNT_W), ex_lock (1 bit).
- Reset (resetn=0, async): all pointers, count, pend, drop_cnt, ex_lock cleared.
  - Outputs then: req_ready=1, fs_to_ds_valid=0, fs_empty=1, inst_sram_data_waiting=0, fs_to_ds_bus=0.
- req_ready = (count<DEPTH) && (pend+drop_cnt<DEPTH) && !ex_lock.
  - pre-IF must not issue an SRAM request while req_ready=0.
- Push (req_valid && req_ready && !flush): entry[wptr] <= {pc=req_pc, ex=req_ex, done=req_ex}; wptr++, count++.
  - If !req_ex: pend++.
  - If req_ex: ex_lock<=1; further pushes are blocked until flush, so every non-ex entry precedes the ex entry.
- Response (data_ok, no flush):
  - If drop_cnt>0: drop_cnt--, data discarded.
  - Else: entry[fptr].inst<=rdata, done<=1, fptr++, pend--.
  - data_ok with drop_cnt==0 and pend==0 is a protocol violation (assertion).
- Output / bypass:
  - fs_to_ds_valid = !flush && count>0 && (entry[rptr].done || (rptr==fptr && data_ok && drop_cnt==0)).
  - inst field = bypass case ? inst_sram_rdata : entry[rptr].inst.
  - ex = entry[rptr].ex; badvaddr = pc = entry[rptr].pc.
- Pop: fs_to_ds_valid && ds_allowin → rptr++, count--.
  - A bypassed response is consumed in the same cycle: fptr and rptr both advance and no write is needed.
- Simultaneous push/pop/response in one cycle: all apply. count and pend each update by the net of their increments and decrements.
- Flush, at the next edge:
  - All entries invalid; rptr=wptr=fptr=0; count=0; pend=0; ex_lock=0.
  - drop_cnt <= drop_cnt + pend + (req_valid && !req_ex) - data_ok.
  - A push accepted in the flush cycle is therefore treated as in flight and dropped, never queued.
  - fs_to_ds_valid=0 during the flush cycle.
- Pointers wrap modulo DEPTH. count==DEPTH is full, count==0 is empty.
- inst_sram_data_waiting = (pend + drop_cnt) != 0.
- fs_empty = (count==0).
- Max latency: a response at cycle t is visible to ID at t (bypass) if it targets the head, else once it reaches the head.

Test Plan:
- Stream: DEPTH=4, push pc 0xBFC00000..0xBFC0000C, data_ok one cycle after each push, ds_allowin=1 → four outputs in order, each same cycle as its data_ok (bypass), inst matches rdata, count never exceeds 1.
- Backpressure/full: ds_allowin=0, 4 pushes + 4 responses → req_ready=0 after the 4th push; release ds_allowin → 4 in-order outputs on 4 consecutive cycles, then req_ready=1.
- Flush with 3 pending: push 3, no data, assert flush → fs_to_ds_valid=0, drop_cnt=3. Push pc 0x80000180 next cycle, then 4 data_ok → first 3 dropped, 4th delivered with pc 0x80000180.
- Flush colliding with data_ok and push: pend=2, drop_cnt=0, flush+data_ok+push(non-ex) same cycle → drop_cnt=2, queue empty, nothing delivered.
- Address error: push pc 0xBFC00002 req_ex=1 behind one pending fetch → req_ready=0. After data_ok: first entry delivered, then ex=1, badvaddr=0xBFC00002. Flush → req_ready=1.
- Async reset mid-operation: deassert resetn between clock edges with 2 entries and drop_cnt=1 → outputs go to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/if_fetch_queue.sv
// In-order instruction fetch queue between pre-IF and ID.
// Buffers SRAM responses, bypasses a response that targets the head, and discards responses from flushed fetches.
module if_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           req_valid,
  input  logic [PC_W-1:0]                req_pc,
  input  logic                           req_ex,
  output logic                           req_ready,
  input  logic                           inst_sram_data_ok,
  input  logic [INST_W-1:0]              inst_sram_rdata,
  input  logic                           flush,
  input  logic                           ds_allowin,
  output logic                           fs_to_ds_valid,
  output logic [1+PC_W+INST_W+PC_W-1:0]  fs_to_ds_bus,
  output logic                           inst_sram_data_waiting,
  output logic                           fs_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]   r_pc   [DEPTH];
  logic [INST_W-1:0] r_inst [DEPTH];
  logic [DEPTH-1:0]  r_ex;
  logic [DEPTH-1:0]  r_done;

  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_fptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_pend;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              r_ex_lock;

  logic [CNT_W-1:0]  w_outstanding;
  logic              w_ready;
  logic              w_push;
  logic              w_resp;
  logic              w_drop;
  logic              w_fill;
  logic              w_nonempty;
  logic              w_head_done;
  logic              w_bypass;
  logic              w_valid;
  logic              w_pop;
  logic [INST_W-1:0] w_head_inst;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [CNT_W-1:0]  w_pend_nxt;
  logic [CNT_W-1:0]  w_flush_drop;

  // pend + drop_cnt never exceeds DEPTH, so the sum fits in CNT_W bits.
  assign w_outstanding = r_pend + r_drop_cnt;
  assign w_ready       = (r_count < CNT_W'(DEPTH)) && (w_outstanding < CNT_W'(DEPTH)) && !r_ex_lock;

  assign w_push      = req_valid && w_ready && !flush;
  assign w_resp      = inst_sram_data_ok && !flush;
  assign w_drop      = w_resp && (r_drop_cnt != '0);
  assign w_fill      = w_resp && (r_drop_cnt == '0);

  assign w_nonempty  = (r_count != '0);
  assign w_head_done = r_done[r_rptr];
  assign w_bypass    = w_nonempty && !w_head_done && (r_rptr == r_fptr) &&
                       inst_sram_data_ok && (r_drop_cnt == '0);
  assign w_valid     = !flush && w_nonempty && (w_head_done || w_bypass);
  assign w_pop       = w_valid && ds_allowin;
  assign w_head_inst = w_bypass ? inst_sram_rdata : r_inst[r_rptr];

  assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_pend_nxt   = r_pend + CNT_W'(w_push && !req_ex) - CNT_W'(w_fill);
  // Everything still in flight after a flush, including a request issued this cycle, is discarded later.
  assign w_flush_drop = r_drop_cnt + r_pend + CNT_W'(req_valid && !req_ex) - CNT_W'(inst_sram_data_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_fptr     <= '0;
      r_count    <= '0;
      r_pend     <= '0;
      r_drop_cnt <= '0;
      r_ex_lock  <= 1'b0;
    end else if (flush) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_fptr     <= '0;
      r_count    <= '0;
      r_pend     <= '0;
      r_drop_cnt <= w_flush_drop;
      r_ex_lock  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_fill) r_fptr <= r_fptr + PTR_W'(1);
      if (w_drop) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      if (w_push && req_ex) r_ex_lock <= 1'b1;
      r_count <= w_count_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // A bypassed fill is still written; the slot is released by the same-cycle pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc   <= '{default: '0};
      r_inst <= '{default: '0};
      r_ex   <= '0;
      r_done <= '0;
    end else if (flush) begin
      r_done <= '0;
    end else begin
      if (w_push) begin
        r_pc[r_wptr]   <= req_pc;
        r_ex[r_wptr]   <= req_ex;
        r_done[r_wptr] <= req_ex;
      end
      if (w_fill) begin
        r_inst[r_fptr] <= inst_sram_rdata;
        r_done[r_fptr] <= 1'b1;
      end
    end
  end

  assign req_ready              = w_ready;
  assign fs_to_ds_valid         = w_valid;
  assign fs_to_ds_bus           = {r_ex[r_rptr], r_pc[r_rptr], w_head_inst, r_pc[r_rptr]};
  assign inst_sram_data_waiting = (w_outstanding != '0);
  assign fs_empty               = !w_nonempty;

`ifndef SYNTHESIS
  // Every SRAM response must belong to a tracked fetch or to one awaiting discard.
  a_resp_has_owner: assert property (@(posedge clk) disable iff (!resetn)
    inst_sram_data_ok |-> ((r_drop_cnt != '0) || (r_pend != '0)));
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_if_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int BUS_W  = 1 + PC_W + INST_W + PC_W;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              req_valid = 1'b0;
  logic [PC_W-1:0]   req_pc = '0;
  logic              req_ex = 1'b0;
  logic              req_ready;
  logic              data_ok = 1'b0;
  logic [INST_W-1:0] rdata = '0;
  logic              flush = 1'b0;
  logic              ds_allowin = 1'b0;
  logic              fs_to_ds_valid;
  logic [BUS_W-1:0]  fs_to_ds_bus;
  logic              waiting;
  logic              fs_empty;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .req_valid              (req_valid),
    .req_pc                 (req_pc),
    .req_ex                 (req_ex),
    .req_ready              (req_ready),
    .inst_sram_data_ok      (data_ok),
    .inst_sram_rdata        (rdata),
    .flush                  (flush),
    .ds_allowin             (ds_allowin),
    .fs_to_ds_valid         (fs_to_ds_valid),
    .fs_to_ds_bus           (fs_to_ds_bus),
    .inst_sram_data_waiting (waiting),
    .fs_empty               (fs_empty)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the queue holds live entries oldest-first.
  typedef struct {
    logic [PC_W-1:0]   pc;
    logic              ex;
    logic [INST_W-1:0] inst;
    logic              done;
  } ment_t;

  ment_t mq[$];
  int    m_drop = 0;
  bit    m_lock = 1'b0;

  function automatic int f_pend();
    int n = 0;
    foreach (mq[i]) if (!mq[i].done) n++;
    return n;
  endfunction

  function automatic bit f_ready();
    return (mq.size() < DEPTH) && ((f_pend() + m_drop) < DEPTH) && !m_lock;
  endfunction

  logic             s_ready, s_valid, s_empty, s_wait;
  logic [BUS_W-1:0] s_bus;

  // One clock: drive at negedge, sample and check at negedge+1, advance model after posedge.
  task automatic cyc(input logic rv, input logic [PC_W-1:0] pc, input logic ex,
                     input logic dok, input logic [INST_W-1:0] rd,
                     input logic fl, input logic al);
    int    pend;
    bit    mready, byp, mval;
    ment_t h;
    ment_t e;
    @(negedge clk);
    req_valid = rv; req_pc = pc; req_ex = ex;
    data_ok = dok; rdata = rd; flush = fl; ds_allowin = al;
    #1;
    s_ready = req_ready; s_valid = fs_to_ds_valid; s_empty = fs_empty;
    s_wait  = waiting;   s_bus   = fs_to_ds_bus;
    pend   = f_pend();
    mready = f_ready();
    h      = '{pc: '0, ex: 1'b0, inst: '0, done: 1'b0};
    if (mq.size() > 0) h = mq[0];
    byp  = (mq.size() > 0) && !h.done && dok && (m_drop == 0);
    mval = !fl && (mq.size() > 0) && (h.done || byp);
    chk("m_ready", s_ready, mready);
    chk("m_valid", s_valid, mval);
    chk("m_empty", s_empty, mq.size() == 0);
    chk("m_waiting", s_wait, (pend + m_drop) != 0);
    if (mval) begin
      chk("m_ex", s_bus[BUS_W-1], h.ex);
      chk("m_badvaddr", s_bus[BUS_W-2 -: PC_W], h.pc);
      chk("m_pc", s_bus[PC_W-1:0], h.pc);
      if (!h.ex) chk("m_inst", s_bus[PC_W +: INST_W], byp ? rd : h.inst);
    end
    @(posedge clk);
    if (fl) begin
      m_drop = m_drop + pend + ((rv && !ex) ? 1 : 0) - (dok ? 1 : 0);
      mq.delete();
      m_lock = 1'b0;
    end else begin
      if (dok) begin
        if (m_drop > 0) m_drop--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].done) begin
              e = mq[i]; e.inst = rd; e.done = 1'b1; mq[i] = e;
              break;
            end
          end
        end
      end
      if (mval && al) void'(mq.pop_front());
      if (rv && mready) begin
        e = '{pc: pc, ex: ex, inst: '0, done: ex};
        mq.push_back(e);
        if (ex) m_lock = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic al);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, al);
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [PC_W-1:0] pc,
                         input logic [INST_W-1:0] inst);
    chk({nm, "_valid"}, s_valid, v);
    if (v) begin
      chk({nm, "_pc"}, s_bus[PC_W-1:0], pc);
      chk({nm, "_inst"}, s_bus[PC_W +: INST_W], inst);
    end
  endtask

  typedef struct {
    logic              rv;
    logic [PC_W-1:0]   pc;
    logic              dok;
    logic [INST_W-1:0] rd;
    logic              e_ready;
    logic              e_valid;
    logic              e_empty;
    logic [PC_W-1:0]   e_pc;
    logic [INST_W-1:0] e_inst;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] r;
    logic        rv, ex, dok, fl, al;
    logic [31:0] pc;

    // Streaming bypass: each response is delivered in the cycle it arrives.
    tbl[0] = '{1'b1, 32'hBFC00000, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        32'h0};
    tbl[1] = '{1'b1, 32'hBFC00004, 1'b1, 32'h11110000, 1'b1, 1'b1, 1'b0, 32'hBFC00000, 32'h11110000};
    tbl[2] = '{1'b1, 32'hBFC00008, 1'b1, 32'h22220000, 1'b1, 1'b1, 1'b0, 32'hBFC00004, 32'h22220000};
    tbl[3] = '{1'b1, 32'hBFC0000C, 1'b1, 32'h33330000, 1'b1, 1'b1, 1'b0, 32'hBFC00008, 32'h33330000};
    tbl[4] = '{1'b0, 32'h0,        1'b1, 32'h44440000, 1'b1, 1'b1, 1'b0, 32'hBFC0000C, 32'h44440000};
    tbl[5] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        32'h0};

    #2;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_valid", fs_to_ds_valid, 1'b0);
    chk("rst_empty", fs_empty, 1'b1);
    chk("rst_waiting", waiting, 1'b0);
    chk("rst_bus_zero", fs_to_ds_bus != '0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].rv, tbl[i].pc, 1'b0, tbl[i].dok, tbl[i].rd, 1'b0, 1'b1);
      chk("tbl_ready", s_ready, tbl[i].e_ready);
      chk("tbl_empty", s_empty, tbl[i].e_empty);
      chk_out("tbl", tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_inst);
      chk("tbl_cnt_le1", dut.r_count <= 1, 1'b1);
    end

    // Backpressure until full, then drain on consecutive cycles.
    for (int k = 0; k < 5; k++)
      cyc(k < 4, 32'(32'hBFC00100 + 4 * k), 1'b0, k > 0, 32'(32'hA0000000 + k - 1), 1'b0, 1'b0);
    chk("bp_full_ready", s_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      chk_out("bp_drain", 1'b1, 32'(32'hBFC00100 + 4 * k), 32'(32'hA0000000 + k));
    end
    idle(1'b1);
    chk("bp_ready_after", s_ready, 1'b1);
    chk("bp_empty_after", s_empty, 1'b1);

    // Flush with three fetches in flight, then a new fetch behind the discards.
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 32'(32'hBFC00200 + 4 * k), 1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("fl3_valid", s_valid, 1'b0);
    cyc(1'b1, 32'h80000180, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("fl3_ready", s_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b1, 32'(32'hDEAD0000 + k), 1'b0, 1'b1);
      chk("fl3_dropped", s_valid, 1'b0);
    end
    cyc(1'b0, '0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1);
    chk_out("fl3_deliver", 1'b1, 32'h80000180, 32'h12345678);
    idle(1'b1);
    chk("fl3_waiting_done", s_wait, 1'b0);

    // Flush coinciding with a response and a new push.
    cyc(1'b1, 32'hBFC00300, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 32'hBFC00304, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 32'hBFC00308, 1'b0, 1'b1, 32'h55555555, 1'b1, 1'b1);
    chk("col_valid", s_valid, 1'b0);
    idle(1'b1);
    chk("col_empty", s_empty, 1'b1);
    chk("col_waiting", s_wait, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b1, 32'h66666666, 1'b0, 1'b1);
      chk("col_dropped", s_valid, 1'b0);
    end
    idle(1'b1);
    chk("col_waiting_done", s_wait, 1'b0);

    // Address-error fetch behind one pending fetch.
    cyc(1'b1, 32'hBFC00400, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 32'hBFC00002, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1, 32'hC0FFEE00, 1'b0, 1'b1);
    chk("ae_locked", s_ready, 1'b0);
    chk_out("ae_first", 1'b1, 32'hBFC00400, 32'hC0FFEE00);
    chk("ae_first_ex", s_bus[BUS_W-1], 1'b0);
    idle(1'b1);
    chk("ae_ex_valid", s_valid, 1'b1);
    chk("ae_ex", s_bus[BUS_W-1], 1'b1);
    chk("ae_badvaddr", s_bus[BUS_W-2 -: PC_W], 32'hBFC00002);
    idle(1'b1);
    chk("ae_still_locked", s_ready, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(1'b1);
    chk("ae_unlocked", s_ready, 1'b1);

    // Asynchronous reset between clock edges with two entries and one discard pending.
    cyc(1'b1, 32'hBFC00500, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    cyc(1'b1, 32'hBFC00504, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 32'hBFC00508, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0; req_ex = 1'b0; data_ok = 1'b0; flush = 1'b0; ds_allowin = 1'b0;
    #1;
    chk("ar_pre_empty", fs_empty, 1'b0);
    chk("ar_pre_waiting", waiting, 1'b1);
    #1 resetn = 1'b0;
    #1;
    chk("ar_ready", req_ready, 1'b1);
    chk("ar_valid", fs_to_ds_valid, 1'b0);
    chk("ar_empty", fs_empty, 1'b1);
    chk("ar_waiting", waiting, 1'b0);
    chk("ar_bus_zero", fs_to_ds_bus != '0, 1'b0);
    mq.delete();
    m_drop = 0;
    m_lock = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // Randomized traffic that respects the pre-IF and SRAM protocol.
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom;
      ex  = ($urandom_range(0, 19) == 0);
      pc  = ex ? ((r & ~32'h3) | 32'h2) : (r & ~32'h3);
      rv  = f_ready() && ($urandom_range(0, 9) < 6);
      dok = ((f_pend() + m_drop) > 0) && ($urandom_range(0, 9) < 5);
      fl  = ($urandom_range(0, 29) == 0);
      al  = ($urandom_range(0, 9) < 7);
      cyc(rv, pc, ex, dok, $urandom, fl, al);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
